// File: rtl/conversor_inverso.sv
// conversor_inverso: BCD digit -> 4-bit HGFE code word encoder (transmit side).
//
// Accepts one BCD digit per valid/ready transfer. It presents the encoded word
// in parallel with a one-cycle strobe, then shifts it out serially, MSB (H)
// first, inside a 4-cycle frame. A GAP-cycle idle window follows each frame
// before the next digit is accepted. Digits above 9 are rejected and counted.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a digit; bad digits are rejected here
// ST_SHIFT | serial frame in progress, 4 bit cycles
// ST_GAP   | idle gap after a frame, GAP cycles
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   bcd_valid, bcd        upstream digit and its qualifier
//   bcd_ready             high in ST_IDLE (decoded from state only)
//   code_out, code_valid  last encoded word and its one-cycle update strobe
//   ser_out, ser_frame    serial bit (H first) and frame window
//   err, err_count        reject pulse and saturating reject counter

module conversor_inverso #(
    parameter int ERR_W = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bcd_valid,
    input  logic [3:0]       bcd,
    output logic             bcd_ready,
    output logic [3:0]       code_out,
    output logic             code_valid,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [3:0]       shreg;
    logic [1:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       enc;
    logic             take;

    function automatic logic [3:0] encode(input logic [3:0] d);
        logic [3:0] w;
        case (d)
            4'd0:    w = 4'b0000;
            4'd1:    w = 4'b0001;
            4'd2:    w = 4'b0011;
            4'd3:    w = 4'b0100;
            4'd4:    w = 4'b0101;
            4'd5:    w = 4'b0111;
            4'd6:    w = 4'b1001;
            4'd7:    w = 4'b1011;
            4'd8:    w = 4'b1100;
            4'd9:    w = 4'b1101;
            default: w = 4'b0000;
        endcase
        return w;
    endfunction

    assign enc       = encode(bcd);
    assign bcd_ready = (state == ST_IDLE);
    assign take      = bcd_valid && bcd_ready;

    // The shift register is all zeros once the frame has been shifted out,
    // and the frame gate keeps the line low in IDLE/GAP regardless.
    assign ser_out = shreg[3] & ser_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= 4'b0000;
            bit_cnt    <= 2'd0;
            gap_cnt    <= '0;
            code_out   <= 4'b0000;
            code_valid <= 1'b0;
            ser_frame  <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
        end else begin
            code_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        if (bcd <= 4'd9) begin
                            code_out   <= enc;
                            code_valid <= 1'b1;
                            shreg      <= enc;
                            bit_cnt    <= 2'd0;
                            ser_frame  <= 1'b1;
                            state      <= ST_SHIFT;
                        end else begin
                            err <= 1'b1;
                            if (err_count != {ERR_W{1'b1}})
                                err_count <= err_count + ERR_W'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg <= {shreg[2:0], 1'b0};
                    if (bit_cnt == 2'd3) begin
                        ser_frame <= 1'b0;
                        gap_cnt   <= GAP_W'(GAP - 1);
                        state     <= ST_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 2'd1;
                    end
                end
                ST_GAP: begin
                    // Down-counter: terminal count releases the link to IDLE.
                    if (gap_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_inverso.sv
module tb_conversor_inverso;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bcd_valid = 1'b0;
    logic [3:0] bcd = 4'd0;
    logic       bcd_ready;
    logic [3:0] code_out;
    logic       code_valid;
    logic       ser_out;
    logic       ser_frame;
    logic       err;
    logic [7:0] err_count;

    logic       bcd_valid2 = 1'b0;
    logic [3:0] bcd2 = 4'd0;
    logic       bcd_ready2;
    logic [3:0] code_out2;
    logic       code_valid2;
    logic       ser_out2;
    logic       ser_frame2;
    logic       err2;
    logic [1:0] err_count2;

    int n_cmp = 0;
    int n_fail = 0;

    logic [3:0] enc_tab [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
                                 4'b0111, 4'b1001, 4'b1011, 4'b1100, 4'b1101};
    logic [7:0] exp_ec = 8'd0;
    logic [3:0] exp_code = 4'b0000;

    conversor_inverso #(.ERR_W(8), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_valid(bcd_valid), .bcd(bcd),
        .bcd_ready(bcd_ready), .code_out(code_out), .code_valid(code_valid),
        .ser_out(ser_out), .ser_frame(ser_frame), .err(err), .err_count(err_count)
    );

    conversor_inverso #(.ERR_W(2), .GAP(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bcd_valid(bcd_valid2), .bcd(bcd2),
        .bcd_ready(bcd_ready2), .code_out(code_out2), .code_valid(code_valid2),
        .ser_out(ser_out2), .ser_frame(ser_frame2), .err(err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int t = 0;
        while (!bcd_ready && t < 20) begin
            tick();
            t++;
        end
        n_cmp++;
        if (bcd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: bcd_ready=%b expected 1", bcd_ready);
        end
    endtask

    // One full frame: transfer, 4 serial bits, gap cycle, ready again.
    // With hold=1, bcd_valid stays high with changing junk while busy.
    task automatic run_frame(input int d, input logic hold);
        logic [3:0] w;
        w = enc_tab[d];
        wait_ready();
        bcd_valid = 1'b1;
        bcd = 4'(d);
        tick();
        exp_code = w;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ser_frame !== 1'b1 || ser_out !== w[3-i]) begin
                n_fail++;
                $display("FAIL ser_bit d=%0d bit=%0d: frame=%b out=%b expected frame=1 out=%b",
                         d, i, ser_frame, ser_out, w[3-i]);
            end
            n_cmp++;
            if (code_out !== w || code_valid !== (i == 0) || bcd_ready !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_outputs d=%0d bit=%0d: code=%b cv=%b rdy=%b err=%b expected code=%b cv=%b rdy=0 err=0",
                         d, i, code_out, code_valid, bcd_ready, err, w, (i == 0));
            end
            bcd_valid = hold;
            bcd = hold ? 4'(i * 5 + 3) : 4'(d);
            tick();
        end
        n_cmp++;
        if (ser_frame !== 1'b0 || ser_out !== 1'b0 || bcd_ready !== 1'b0 ||
            err !== 1'b0 || err_count !== exp_ec || code_out !== w) begin
            n_fail++;
            $display("FAIL gap_cycle d=%0d: frame=%b out=%b rdy=%b err=%b ec=%0d code=%b expected 0 0 0 0 %0d %b",
                     d, ser_frame, ser_out, bcd_ready, err, err_count, code_out, exp_ec, w);
        end
        tick();
        n_cmp++;
        if (bcd_ready !== 1'b1 || ser_frame !== 1'b0 || code_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_again d=%0d: rdy=%b frame=%b cv=%b expected 1 0 0",
                     d, bcd_ready, ser_frame, code_valid);
        end
        bcd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #20;
        n_cmp++;
        if ({bcd_ready, code_out, code_valid, ser_out, ser_frame, err, err_count} !==
            {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b code=%b cv=%b so=%b sf=%b err=%b ec=%0d expected 1 0000 0 0 0 0 0",
                     bcd_ready, code_out, code_valid, ser_out, ser_frame, err, err_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        for (int d = 0; d < 10; d++) run_frame(d, 1'b1);
    endtask

    task automatic test_digit7;
        run_frame(7, 1'b0);
    endtask

    task automatic test_errors;
        logic [3:0] bad [3] = '{4'd10, 4'd12, 4'd15};
        wait_ready();
        bcd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bcd = bad[i];
            tick();
            exp_ec = exp_ec + 8'd1;
            n_cmp++;
            if (err !== 1'b1 || err_count !== exp_ec) begin
                n_fail++;
                $display("FAIL err_pulse bcd=%0d: err=%b ec=%0d expected err=1 ec=%0d",
                         bad[i], err, err_count, exp_ec);
            end
            n_cmp++;
            if (code_valid !== 1'b0 || ser_frame !== 1'b0 || bcd_ready !== 1'b1 || code_out !== exp_code) begin
                n_fail++;
                $display("FAIL err_side bcd=%0d: cv=%b sf=%b rdy=%b code=%b expected 0 0 1 %b",
                         bad[i], code_valid, ser_frame, bcd_ready, code_out, exp_code);
            end
        end
        bcd_valid = 1'b0;
        tick();
        n_cmp++;
        if (err !== 1'b0 || err_count !== exp_ec) begin
            n_fail++;
            $display("FAIL err_settle: err=%b ec=%0d expected err=0 ec=%0d", err, err_count, exp_ec);
        end
    endtask

    task automatic test_saturation;
        logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bcd_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bcd2 = 4'(10 + i);
            tick();
            n_cmp++;
            if (err2 !== 1'b1 || err_count2 !== exp2[i]) begin
                n_fail++;
                $display("FAIL err_sat n=%0d: err=%b ec=%0d expected err=1 ec=%0d",
                         i + 1, err2, err_count2, exp2[i]);
            end
            n_cmp++;
            if (code_valid2 !== 1'b0 || ser_frame2 !== 1'b0 || ser_out2 !== 1'b0 ||
                bcd_ready2 !== 1'b1 || code_out2 !== 4'b0000) begin
                n_fail++;
                $display("FAIL err_sat_side n=%0d: cv=%b sf=%b so=%b rdy=%b code=%b expected 0 0 0 1 0000",
                         i + 1, code_valid2, ser_frame2, ser_out2, bcd_ready2, code_out2);
            end
        end
        bcd_valid2 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_frame;
        wait_ready();
        bcd_valid = 1'b1;
        bcd = 4'd9;
        tick();
        bcd_valid = 1'b0;
        n_cmp++;
        if (ser_frame !== 1'b1 || ser_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_bit0: sf=%b so=%b expected 1 1", ser_frame, ser_out);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bcd_ready, code_out, code_valid, ser_out, ser_frame, err, err_count} !==
            {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b code=%b cv=%b so=%b sf=%b err=%b ec=%0d expected 1 0000 0 0 0 0 0",
                     bcd_ready, code_out, code_valid, ser_out, ser_frame, err, err_count);
        end
        exp_ec = 8'd0;
        tick();
        tick();
        n_cmp++;
        if (ser_frame !== 1'b0 || ser_out !== 1'b0) begin
            n_fail++;
            $display("FAIL held_reset: sf=%b so=%b expected 0 0", ser_frame, ser_out);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (ser_frame !== 1'b0 || code_out !== 4'b0000 || bcd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_release: sf=%b code=%b rdy=%b expected 0 0000 1",
                     ser_frame, code_out, bcd_ready);
        end
        run_frame(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_digit7();
        test_errors();
        test_saturation();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
